digit_serial_adder16: RTL



---
 rtl/adder_pkg.sv | 18 +
 rtl/digit_serial_adder16_if.sv | 33 +++
 rtl/r4_adder.sv | 12 +
 rtl/digit_serial_adder16.sv | 97 +++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the digit-serial adder: slice width, FSM encodings and
// a helper for sizing the slice counter.
package adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slice counter width; never narrower than one bit.
  function automatic int cnt_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder16_if.sv
// Operand/result channels of digit_serial_adder16.
// DIGIT_SERIAL_ADDER_OVF_EN adds the signed-overflow flag ovf.
interface digit_serial_adder16_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/r4_adder.sv
// Combinational 4-bit ripple-carry slice: {cout, s} = a + b + cin.
module r4_adder
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);
  assign {cout, s} = (SLICE_W+1)'(a) + (SLICE_W+1)'(b) + (SLICE_W+1)'(cin);
endmodule

// File: rtl/digit_serial_adder16.sv
// Digit-serial WIDTH-bit adder: one 4-bit ripple slice per cycle, LSB first,
// inter-slice carry kept in a register. Optional ovf via DIGIT_SERIAL_ADDER_OVF_EN.
module digit_serial_adder16
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = SLICE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  digit_serial_adder16_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = cnt_w(NSLICE);

  state_e                        state_q, state_d;
  logic [CW-1:0]                 cnt_q;
  logic                          carry_q;
  logic [NSLICE-1:0][SLICE-1:0]  opa_q, opb_q, res_q;
  logic                          cout_q;
  logic                          accept, last;
  logic [SLICE-1:0]              sl_a, sl_b, sl_s;
  logic                          sl_c;

  assign bus.in_ready  = ~rst & ((state_q == ST_IDLE) |
                                 ((state_q == ST_DONE) & bus.out_ready));
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_BUSY);
  assign bus.sum       = res_q;
  assign bus.cout      = cout_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign last   = (cnt_q == CW'(NSLICE - 1));
  assign sl_a   = opa_q[cnt_q];
  assign sl_b   = opb_q[cnt_q];

  r4_adder u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_c)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (last)   state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = bus.in_valid ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath. The result register is only rewritten slice by slice in BUSY,
  // so sum stays put in DONE and after returning to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      opa_q   <= bus.a;
      opb_q   <= bus.b;
      carry_q <= bus.cin;
      cnt_q   <= '0;
    end else if (state_q == ST_BUSY) begin
      res_q[cnt_q] <= sl_s;
      carry_q      <= sl_c;
      cnt_q        <= cnt_q + CW'(1);
      if (last) cout_q <= sl_c;
    end
  end

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic ovf_q;
  logic msb_cin;

  // Carry into the MSB recovered from the sum bit: s = a ^ b ^ c_in.
  assign msb_cin = sl_a[SLICE-1] ^ sl_b[SLICE-1] ^ sl_s[SLICE-1];
  assign bus.ovf = ovf_q;

  always_ff @(posedge clk) begin
    if (rst)                                ovf_q <= 1'b0;
    else if (!accept && state_q == ST_BUSY && last) ovf_q <= msb_cin ^ sl_c;
  end
`endif

endmodule
